// File: rtl/exec_pkg.sv
// exec_pkg: shared encodings for the R-type execute slice (ALU selects, ALUOp, funct)
package exec_pkg;

    typedef enum logic [2:0] {
        SEL_AND = 3'b000,
        SEL_OR  = 3'b001,
        SEL_ADD = 3'b010,
        SEL_XOR = 3'b011,
        SEL_NOR = 3'b100,
        SEL_SUB = 3'b110,
        SEL_SLT = 3'b111
    } alu_sel_e;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/regfile_alu_exec_if.sv
// regfile_alu_exec_if: instruction-field/control inputs and execute results of the slice
interface regfile_alu_exec_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [5:0]        funct;
    logic [2:0]        alu_op;
    logic              reg_write;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] alu_result;
    logic              zero;
    logic              illegal;

    modport master (
        output rs_addr, rt_addr, rd_addr, funct, alu_op, reg_write, wb_data,
        input  rs_data, rt_data, alu_result, zero, illegal
    );

    modport slave (
        input  rs_addr, rt_addr, rd_addr, funct, alu_op, reg_write, wb_data,
        output rs_data, rt_data, alu_result, zero, illegal
    );
endinterface

// File: rtl/exec_regfile.sv
// exec_regfile: register bank with two combinational read ports and one clocked write port
module exec_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_rs_addr,
    input  logic [ADDR_W-1:0] i_rt_addr,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0] i_wd,
    output logic [DATA_W-1:0] o_rs_data,
    output logic [DATA_W-1:0] o_rt_data
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] reg_mem [0:DEPTH-1];

    // Clear everything on reset; write on the edge, never touching register 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) reg_mem[i] <= '0;
        end else if (i_we && i_rd_addr != '0) begin
            reg_mem[i_rd_addr] <= i_wd;
        end
    end

    assign o_rs_data = (i_rs_addr == '0) ? '0 : reg_mem[i_rs_addr];
    assign o_rt_data = (i_rt_addr == '0) ? '0 : reg_mem[i_rt_addr];
endmodule

// File: rtl/regfile_alu_exec.sv
// regfile_alu_exec: register bank, ALU-control decode and 32-bit ALU for R-type execute
module regfile_alu_exec
    import exec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    regfile_alu_exec_if.slave     bus
);
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic [DATA_W-1:0] w_result;
    alu_sel_e          w_sel;
    logic              w_illegal;

    exec_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_regfile (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_we      (bus.reg_write),
        .i_rs_addr (bus.rs_addr),
        .i_rt_addr (bus.rt_addr),
        .i_rd_addr (bus.rd_addr),
        .i_wd      (bus.wb_data),
        .o_rs_data (w_rs_data),
        .o_rt_data (w_rt_data)
    );

    // Map ALUOp (and funct for R-type) to an ALU select; unknown funct falls back to ADD
    always_comb begin
        w_sel     = SEL_ADD;
        w_illegal = 1'b0;
        case (bus.alu_op)
            ALUOP_SUB: w_sel = SEL_SUB;
            ALUOP_AND: w_sel = SEL_AND;
            ALUOP_OR:  w_sel = SEL_OR;
            ALUOP_SLT: w_sel = SEL_SLT;
            ALUOP_RTYPE: begin
                case (bus.funct)
                    FUNCT_ADD: w_sel = SEL_ADD;
                    FUNCT_SUB: w_sel = SEL_SUB;
                    FUNCT_AND: w_sel = SEL_AND;
                    FUNCT_OR:  w_sel = SEL_OR;
                    FUNCT_XOR: w_sel = SEL_XOR;
                    FUNCT_NOR: w_sel = SEL_NOR;
                    FUNCT_SLT: w_sel = SEL_SLT;
                    default:   w_illegal = 1'b1;
                endcase
            end
            default: w_sel = SEL_ADD;
        endcase
    end

    // ALU: wrap-around arithmetic, subtraction as A + ~B + 1, signed set-less-than
    always_comb begin
        w_result = '0;
        case (w_sel)
            SEL_AND: w_result = w_rs_data & w_rt_data;
            SEL_OR:  w_result = w_rs_data | w_rt_data;
            SEL_ADD: w_result = w_rs_data + w_rt_data;
            SEL_XOR: w_result = w_rs_data ^ w_rt_data;
            SEL_NOR: w_result = ~(w_rs_data | w_rt_data);
            SEL_SUB: w_result = w_rs_data + ~w_rt_data + 1'b1;
            SEL_SLT: w_result = {{(DATA_W-1){1'b0}}, $signed(w_rs_data) < $signed(w_rt_data)};
            default: w_result = '0;
        endcase
    end

    assign bus.rs_data    = w_rs_data;
    assign bus.rt_data    = w_rt_data;
    assign bus.alu_result = w_result;
    assign bus.zero       = (w_result == '0);
    assign bus.illegal    = w_illegal;
endmodule

// File: tb/tb_regfile_alu_exec.sv
// tb_regfile_alu_exec: directed and randomized checks of the execute slice against a reference model
module tb_regfile_alu_exec;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] model [0:31];
    logic [5:0]  legal [0:6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                 6'b100110, 6'b100111, 6'b101010};

    regfile_alu_exec_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_alu_exec dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic string op_name(input logic [2:0] op, input logic [5:0] f);
        if (op == 3'd1) return "sub";
        if (op == 3'd3) return "and";
        if (op == 3'd4) return "or";
        if (op == 3'd5) return "slt";
        if (op != 3'd2) return "add";
        if (f == 6'b100000) return "add";
        if (f == 6'b100010) return "sub";
        if (f == 6'b100100) return "and";
        if (f == 6'b100101) return "or";
        if (f == 6'b100110) return "xor";
        if (f == 6'b100111) return "nor";
        if (f == 6'b101010) return "slt";
        return "bad";
    endfunction

    function automatic logic [31:0] ref_alu(input string k, input logic [31:0] a, input logic [31:0] b);
        if (k == "sub") return a - b;
        if (k == "and") return a & b;
        if (k == "or")  return a | b;
        if (k == "xor") return a ^ b;
        if (k == "nor") return ~(a | b);
        if (k == "slt") return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        return a + b;
    endfunction

    task automatic check_all(input string tag);
        string k;
        logic [31:0] a, b, r;
        k = op_name(bus.alu_op, bus.funct);
        a = model[bus.rs_addr];
        b = model[bus.rt_addr];
        r = ref_alu(k, a, b);
        check({tag, ".rs"}, bus.rs_data, a);
        check({tag, ".rt"}, bus.rt_data, b);
        check({tag, ".res"}, bus.alu_result, r);
        check({tag, ".zero"}, {31'b0, bus.zero}, {31'b0, r == 32'd0});
        check({tag, ".ill"}, {31'b0, bus.illegal}, {31'b0, k == "bad"});
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.rd_addr = a;
        bus.wb_data = d;
        bus.reg_write = 1'b1;
        @(posedge clk);
        #1;
        bus.reg_write = 1'b0;
        if (a != 5'd0) model[a] = d;
    endtask

    task automatic exec(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [2:0] op, input logic [5:0] f);
        @(negedge clk);
        bus.rs_addr = rs;
        bus.rt_addr = rt;
        bus.alu_op = op;
        bus.funct = f;
        #1;
        check_all(tag);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        bus.rs_addr = '0;
        bus.rt_addr = '0;
        bus.rd_addr = '0;
        bus.funct = '0;
        bus.alu_op = 3'b000;
        bus.reg_write = 1'b0;
        bus.wb_data = '0;
        #12;
        check("reset_zero", {31'b0, bus.zero}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i < 32; i++) begin
            bus.rs_addr = 5'(i);
            #1;
            check($sformatf("reset_r%0d", i), bus.rs_data, 32'd0);
        end
        exec("reset_add", 5'd3, 5'd4, 3'b000, 6'd0);

        wr(5'd8, 32'h0000_0005);
        wr(5'd9, 32'h0000_0003);
        exec("add89", 5'd8, 5'd9, 3'b010, 6'b100000);
        check("add89_lit", bus.alu_result, 32'd8);
        exec("sub89", 5'd8, 5'd9, 3'b010, 6'b100010);
        check("sub89_lit", bus.alu_result, 32'd2);

        wr(5'd10, 32'hFFFF_FFFF);
        exec("slt10_9", 5'd10, 5'd9, 3'b010, 6'b101010);
        check("slt10_9_lit", bus.alu_result, 32'd1);
        exec("slt9_10", 5'd9, 5'd10, 3'b010, 6'b101010);
        check("slt9_10_lit", bus.alu_result, 32'd0);

        wr(5'd0, 32'hDEAD_BEEF);
        exec("r0_write", 5'd0, 5'd8, 3'b000, 6'd0);
        check("r0_lit", bus.rs_data, 32'd0);
        @(negedge clk);
        bus.rd_addr = 5'd8;
        bus.wb_data = 32'hCAFE_F00D;
        bus.reg_write = 1'b0;
        @(posedge clk);
        #1;
        exec("no_we", 5'd8, 5'd9, 3'b000, 6'd0);
        check("no_we_lit", bus.rs_data, 32'd5);

        @(negedge clk);
        bus.rs_addr = 5'd8;
        bus.rd_addr = 5'd8;
        bus.wb_data = 32'h0000_1234;
        bus.reg_write = 1'b1;
        #1;
        check("rdw_before", bus.rs_data, 32'd5);
        @(posedge clk);
        #1;
        bus.reg_write = 1'b0;
        model[8] = 32'h0000_1234;
        check("rdw_after", bus.rs_data, 32'h0000_1234);

        exec("illegal", 5'd8, 5'd9, 3'b010, 6'b000000);
        check("illegal_lit", {31'b0, bus.illegal}, 32'd1);
        check("illegal_add", bus.alu_result, 32'h0000_1237);
        for (int o = 0; o < 8; o++) exec($sformatf("aluop%0d", o), 5'd10, 5'd9, 3'(o), 6'b000000);
        exec("sub_self", 5'd9, 5'd9, 3'b001, 6'd0);

        for (int n = 0; n < 60; n++) begin
            logic [4:0] rs, rt;
            logic [5:0] f;
            if ($urandom_range(0, 1) == 0) wr(5'($urandom_range(0, 31)), $urandom);
            rs = 5'($urandom_range(0, 31));
            rt = ($urandom_range(0, 4) == 0) ? rs : 5'($urandom_range(0, 31));
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal[$urandom_range(0, 6)];
            exec($sformatf("rnd%0d", n), rs, rt, 3'($urandom_range(0, 7)), f);
        end

        @(negedge clk);
        bus.rs_addr = 5'd9;
        bus.rt_addr = 5'd10;
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        check("async_rs", bus.rs_data, 32'd0);
        check("async_rt", bus.rt_data, 32'd0);
        for (int i = 1; i < 32; i++) begin
            bus.rs_addr = 5'(i);
            #0.1;
            check($sformatf("async_r%0d", i), bus.rs_data, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exec("post_reset", 5'd8, 5'd10, 3'b000, 6'd0);
        wr(5'd5, 32'h8000_0000);
        exec("post_wr", 5'd5, 5'd5, 3'b010, 6'b100000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
